// File: rtl/fpu_div_pkg.sv
// rtl/fpu_div_pkg.sv - shared FPU divider constants and mantissa-iterator state encoding
//
// Purpose : common definitions for the FPU divider mantissa datapath.
// Contents: DIV_WIDTH   default mantissa width including hidden bit
//           div_state_e iterator FSM state encoding (IDLE/RUN/DONE)
package fpu_div_pkg;

  localparam int DIV_WIDTH = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage : fpu_div_pkg

// File: rtl/div_m_step.sv
// rtl/div_m_step.sv - one restoring-division step: compare, conditional subtract, shift
//
// Purpose : single combinational iteration of the mantissa divider.
// Ports   : rem_i   [WIDTH:0]   current partial remainder (always < 2*b_i)
//           b_i     [WIDTH-1:0] divisor mantissa
//           rem_o   [WIDTH:0]   next partial remainder, already shifted left by one
//           q_o                 quotient bit produced by this step
module div_m_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] sel;

  assign b_ext = {1'b0, b_i};
  assign q_o   = (rem_i >= b_ext);
  assign diff  = rem_i - b_ext;
  assign sel   = q_o ? diff : rem_i;
  // sel < b_i here, so the shift never drops a set bit.
  assign rem_o = sel << 1;

endmodule : div_m_step

// File: rtl/fpu_div_mant_iter.sv
// rtl/fpu_div_mant_iter.sv - iterative restoring mantissa divider, one quotient bit per cycle
//
// Purpose : quot = floor(a_mant * 2^(WIDTH-1) / b_mant) with sticky, div-by-zero
//           and overflow flags; WIDTH iterations, outputs held until next start.
// Ports   : clk, rst (async active-high)
//           start           request; sampled only in IDLE
//           a_mant, b_mant  dividend / divisor mantissas [WIDTH-1:0]
//           busy            high from the cycle after start through the done cycle
//           done            one-cycle pulse when results are valid
//           quot            quotient [WIDTH-1:0]
//           rem_nz          sticky: final remainder nonzero
//           dbz, ovf        divisor zero / quotient wider than WIDTH bits
module fpu_div_mant_iter
  import fpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_mant,
  input  logic [WIDTH-1:0] b_mant,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic             rem_nz,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             rem_nz_q, rem_nz_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             a_ovf;

  div_m_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .b_i   (b_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Quotient needs more than WIDTH bits when a >= 2*b.
  assign a_ovf = ({1'b0, a_mant} >= {b_mant, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_nz_q <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_nz_q <= rem_nz_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_nz_d = rem_nz_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d      = b_mant;
          rem_d    = {1'b0, a_mant};
          cnt_d    = CW'(WIDTH - 1);
          quot_d   = '0;
          rem_nz_d = 1'b0;
          dbz_d    = 1'b0;
          ovf_d    = 1'b0;
          if (b_mant == '0) begin
            dbz_d   = 1'b1;
            quot_d  = '1;
            state_d = S_DONE;
          end else if (a_ovf) begin
            ovf_d    = 1'b1;
            quot_d   = '1;
            rem_nz_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        quot_d[cnt_q] = step_q;
        rem_d         = step_rem;
        if (cnt_q == '0) begin
          rem_nz_d = |step_rem;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign quot   = quot_q;
  assign rem_nz = rem_nz_q;
  assign dbz    = dbz_q;
  assign ovf    = ovf_q;

endmodule : fpu_div_mant_iter

// File: tb/tb_fpu_div_mant_iter.sv
// tb/tb_fpu_div_mant_iter.sv - directed self-checking bench for fpu_div_mant_iter
module tb_fpu_div_mant_iter;

  localparam int W = 24;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_mant;
  logic [W-1:0] b_mant;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic         rem_nz;
  logic         dbz;
  logic         ovf;

  int passed = 0;
  int total  = 0;

  fpu_div_mant_iter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_mant (a_mant),
    .b_mant (b_mant),
    .busy   (busy),
    .done   (done),
    .quot   (quot),
    .rem_nz (rem_nz),
    .dbz    (dbz),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".busy"},   32'(busy),   32'd0);
    check({tag, ".done"},   32'(done),   32'd0);
    check({tag, ".quot"},   32'(quot),   32'd0);
    check({tag, ".rem_nz"}, 32'(rem_nz), 32'd0);
    check({tag, ".dbz"},    32'(dbz),    32'd0);
    check({tag, ".ovf"},    32'(ovf),    32'd0);
  endtask

  // Launch one division and follow it to done. Cycle 1 is the cycle after the
  // sampling edge. A nonzero inj_cyc drives a competing start during that cycle.
  task automatic run_div(input string tag,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_q, input logic exp_nz,
                         input logic exp_dbz, input logic exp_ovf, input int exp_cyc,
                         input int inj_cyc, input logic [W-1:0] inj_a,
                         input logic [W-1:0] inj_b);
    int cyc;
    int busy_cnt;
    bit got;
    @(negedge clk);
    start  = 1'b1;
    a_mant = a;
    b_mant = b;
    @(posedge clk);
    #1 start = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
      end else begin
        if (inj_cyc != 0 && cyc == inj_cyc) begin
          start  = 1'b1;
          a_mant = inj_a;
          b_mant = inj_b;
        end
        @(posedge clk);
        #1 start = 1'b0;
        cyc++;
      end
    end
    check({tag, ".done_seen"}, 32'(got),      32'd1);
    check({tag, ".done_cyc"},  32'(cyc),      32'(exp_cyc));
    check({tag, ".busy_cyc"},  32'(busy_cnt), 32'(exp_cyc));
    check({tag, ".quot"},      32'(quot),     32'(exp_q));
    check({tag, ".rem_nz"},    32'(rem_nz),   32'(exp_nz));
    check({tag, ".dbz"},       32'(dbz),      32'(exp_dbz));
    check({tag, ".ovf"},       32'(ovf),      32'(exp_ovf));
    @(posedge clk);
    #1;
    check({tag, ".done_after"}, 32'(done), 32'd0);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check({tag, ".quot_held"},  32'(quot), 32'(exp_q));
  endtask

  initial begin
    int done_cnt;
    rst    = 1'b1;
    start  = 1'b0;
    a_mant = '0;
    b_mant = '0;
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1.5 / 1.0
    run_div("d15_10", 24'hC00000, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, 25, 0, '0, '0);
    // 1.0 / 1.5, started back-to-back in the IDLE cycle after done
    run_div("d10_15", 24'h800000, 24'hC00000, 24'h555555, 1'b1, 1'b0, 1'b0, 25, 0, '0, '0);
    // divide by zero
    run_div("dbz", 24'h800000, 24'h000000, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1, 0, '0, '0);
    // overflow
    run_div("ovf", 24'h800000, 24'h000001, 24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1, 0, '0, '0);
    // overflow boundary: a == 2*b overflows, a == 2*b-1 does not
    run_div("ovf_eq", 24'h000004, 24'h000002, 24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1, 0, '0, '0);
    run_div("ovf_lt", 24'h000003, 24'h000002, 24'hC00000, 1'b0, 1'b0, 1'b0, 25, 0, '0, '0);
    // zero dividend through the normal path
    run_div("a_zero", 24'h000000, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b0, 25, 0, '0, '0);
    // equal operands
    run_div("a_eq_b", 24'hFFFFFF, 24'hFFFFFF, 24'h800000, 1'b0, 1'b0, 1'b0, 25, 0, '0, '0);
    // unnormalized 1/3: floor(2^23/3) = 0x2AAAAA, remainder 2
    run_div("d1_3", 24'h000001, 24'h000003, 24'h2AAAAA, 1'b1, 1'b0, 1'b0, 25, 0, '0, '0);

    // outputs hold while idle
    repeat (5) @(posedge clk);
    #1 check("hold.quot",   32'(quot),   32'h2AAAAA);
    check("hold.rem_nz", 32'(rem_nz), 32'd1);

    // second start at cycle 10 is ignored (would otherwise be an overflow)
    run_div("ign2nd", 24'hC00000, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, 25, 10,
            24'h800000, 24'h000001);

    // dbz/ovf cleared by a later accepted start
    run_div("dbz2", 24'h123456, 24'h000000, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1, 0, '0, '0);
    run_div("clr", 24'hC00000, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, 25, 0, '0, '0);

    // reset in cycle 12 of a run
    @(negedge clk);
    start  = 1'b1;
    a_mant = 24'h800000;
    b_mant = 24'hC00000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 check("mid.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1 check_zero_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("mid.no_done", 32'(done_cnt), 32'd0);
    run_div("post_rst", 24'h800000, 24'hC00000, 24'h555555, 1'b1, 1'b0, 1'b0, 25, 0, '0, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_fpu_div_mant_iter

// File: doc/fpu_div_mant_iter.md
FPU_DIV_MANT_ITER -- requirements
Module: fpu_div_mant_iter

Interface
REQ-001 SHALL have parameter: WIDTH, 24, mantissa width including hidden bit.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a new division; sampled only when idle.
REQ-005 SHALL have port: a_mant  input  WIDTH  dividend mantissa, hidden bit at MSB; may be unnormalized.
REQ-006 SHALL have port: b_mant  input  WIDTH  divisor mantissa, hidden bit at MSB; may be unnormalized.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when results are valid.
REQ-009 SHALL have port: quot  output  WIDTH  floor(a_mant*2^(WIDTH-1)/b_mant); feeds the divider leading-zero counter.
REQ-010 SHALL have port: rem_nz  output  1  sticky bit; final remainder nonzero.
REQ-011 SHALL have port: dbz  output  1  divisor was zero.
REQ-012 SHALL have port: ovf  output  1  quotient would exceed WIDTH bits (a_mant >= 2*b_mant).

Function
REQ-013 SHALL use states IDLE, RUN, DONE.
- IDLE->RUN on start with valid operands.
- IDLE->DONE on start with dbz/ovf.
- RUN->DONE after WIDTH iterations.
- DONE->IDLE unconditionally.
REQ-014 SHALL, on start in IDLE, latch b_mant, load partial remainder (WIDTH+1 bits) = a_mant, clear quotient register, load iteration counter = WIDTH-1.
REQ-015 SHALL, in each RUN cycle: if rem >= b, set quotient bit[counter] = 1 and rem = rem - b, else set bit to 0; then rem = rem << 1 and counter decrements.
REQ-016 SHALL perform exactly one iteration per cycle; start sampled in cycle 0 -> done high in cycle WIDTH+1 (25 for default).
REQ-017 SHALL hold busy high from the cycle after start through the cycle done is high.
REQ-018 SHALL ignore start while busy; in-flight operation unaffected.
REQ-019 SHALL, when b_mant == 0 at start, skip RUN: done in cycle 1, quot = all ones, rem_nz = 0, dbz = 1, ovf = 0.
REQ-020 SHALL, when b_mant != 0 and a_mant >= (b_mant << 1), skip RUN: done in cycle 1, quot = all ones, rem_nz = 1, ovf = 1, dbz = 0.
REQ-021 SHALL produce quot = 0, rem_nz = 0 for a_mant == 0 via the normal RUN path.
REQ-022 SHALL hold quot, rem_nz, dbz and ovf stable from the done cycle until the next accepted start.
REQ-023 SHALL clear dbz and ovf on every accepted start.
REQ-024 SHALL accept a new start in the cycle after the done cycle (IDLE), with no minimum gap beyond that.

Reset
REQ-025 SHALL, on rst high, asynchronously force state = IDLE, busy = 0, done = 0, quot = 0, rem_nz = 0, dbz = 0, ovf = 0, counter = 0, remainder = 0.
REQ-026 SHALL abort any in-flight division on reset mid-RUN, with no done pulse after reset release.
REQ-027 SHALL first sample start on the first rising edge after rst deasserts.

Structure
REQ-028 SHALL place state encoding (IDLE/RUN/DONE) and the default WIDTH constant in the shared FPU divider package/header, fpu_div_pkg.
REQ-029 SHALL implement the compare/subtract/shift step as one combinational sub-module, div_m_step (inputs rem, b; outputs next rem, q bit).
REQ-030 SHALL contain no combinational path from start, a_mant or b_mant to any output.

Verification
REQ-031 SHALL cover 1.5/1.0: a_mant = C00000, b_mant = 800000 -> done at cycle 25, quot = C00000, rem_nz = 0, dbz = ovf = 0.
REQ-032 SHALL cover 1.0/1.5: a_mant = 800000, b_mant = C00000 -> quot = 555555, rem_nz = 1 (quot[23] = 0, downstream count = 1).
REQ-033 SHALL cover the zero divisor: b_mant = 0, a_mant = 800000 -> done at cycle 1, quot = FFFFFF, dbz = 1, busy high for exactly 1 cycle.
REQ-034 SHALL cover overflow: a_mant = 800000, b_mant = 000001 -> done at cycle 1, ovf = 1, quot = FFFFFF, rem_nz = 1.
REQ-035 SHALL cover a second start at cycle 10 of a running division -> ignored; first result unchanged at cycle 25.
REQ-036 SHALL cover reset: rst pulsed at cycle 12 of RUN -> all outputs 0 immediately, no done; a new start after release gives the correct result at +25.
